// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the writeback/commit stage: memory-type codes,
// FSM states and the bit layout of the WB control field.
package wb_commit_stage_pkg;

  localparam logic [2:0] MT_LB  = 3'b000;
  localparam logic [2:0] MT_LH  = 3'b001;
  localparam logic [2:0] MT_LW  = 3'b010;
  localparam logic [2:0] MT_LBU = 3'b100;
  localparam logic [2:0] MT_LHU = 3'b101;

  localparam int WE_BIT = 0;
  localparam int RD_LSB = 1;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_commit_stage_load_align.sv
// Combinational load aligner: extracts and extends the addressed byte/halfword
// from a raw memory word, and flags misaligned halfword/word accesses.
module load_align
  import wb_commit_stage_pkg::*;
#(
  parameter int size       = 32,
  parameter int MEM_TYPE_W = 3
) (
  input  logic [size-1:0]       rdata,
  input  logic [MEM_TYPE_W-1:0] mem_type,
  input  logic [1:0]            addr_lo,
  output logic [size-1:0]       aligned,
  output logic                  misaligned
);

  logic [size-1:0] shifted;
  logic [15:0]     half;

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Undefined encodings fall into the default arm and behave as LW.
  always_comb begin
    aligned    = rdata;
    misaligned = 1'b0;
    case (mem_type)
      MT_LB:  aligned = {{(size-8){shifted[7]}}, shifted[7:0]};
      MT_LBU: aligned = {{(size-8){1'b0}}, shifted[7:0]};
      MT_LH: begin
        aligned    = {{(size-16){half[15]}}, half};
        misaligned = addr_lo[0];
      end
      MT_LHU: begin
        aligned    = {{(size-16){1'b0}}, half};
        misaligned = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback commit stage: registers ALU results or aligned load data onto the
// register-file write port. Optional retire counter under WB_RETIRE_CNT_EN.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int size       = 32,
  parameter int MEM_TYPE_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4:0]            rd_i,
  input  logic                  we_i,
  input  logic                  md_i,
  input  logic [MEM_TYPE_W-1:0] mem_type_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [size-1:0]       alu_result_i,
  input  logic                  rdata_valid_i,
  input  logic [size-1:0]       rdata_i,
  output logic [5:0]            Control_Signal_WB,
  output logic [size-1:0]       DATA_in_WB,
  output logic                  misalign_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           retire_cnt_o
`endif
);

  wb_state_e state_q, state_d;

  logic [4:0]            rd_q, cap_rd;
  logic                  we_q, cap_we, misalign_q;
  logic [size-1:0]       data_q;
  logic [MEM_TYPE_W-1:0] cap_mt;
  logic [1:0]            cap_addr;

  logic                  commit, capture, misalign_d;
  logic [4:0]            commit_rd;
  logic                  commit_we, we_d;
  logic [size-1:0]       commit_data;

  logic [MEM_TYPE_W-1:0] al_mt;
  logic [1:0]            al_addr;
  logic [size-1:0]       al_data;
  logic                  al_misaligned;

  // One aligner serves both uses: misalign check on the incoming request in
  // IDLE, data alignment with the captured request in WAIT_LOAD.
  assign al_mt   = (state_q == WB_IDLE) ? mem_type_i : cap_mt;
  assign al_addr = (state_q == WB_IDLE) ? addr_lo_i  : cap_addr;

  load_align #(.size(size), .MEM_TYPE_W(MEM_TYPE_W)) u_align (
    .rdata      (rdata_i),
    .mem_type   (al_mt),
    .addr_lo    (al_addr),
    .aligned    (al_data),
    .misaligned (al_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    commit      = 1'b0;
    capture     = 1'b0;
    misalign_d  = 1'b0;
    commit_rd   = rd_i;
    commit_we   = we_i;
    commit_data = alu_result_i;
    case (state_q)
      WB_IDLE: begin
        if (valid_i) begin
          if (!md_i) begin
            commit = 1'b1;
          end else if (al_misaligned) begin
            misalign_d = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = WB_WAIT_LOAD;
          end
        end
      end
      WB_WAIT_LOAD: begin
        if (rdata_valid_i) begin
          commit      = 1'b1;
          commit_rd   = cap_rd;
          commit_we   = cap_we;
          commit_data = al_data;
          state_d     = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign we_d = commit & commit_we & (commit_rd != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WB_IDLE;
      rd_q       <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      misalign_q <= 1'b0;
      cap_rd     <= '0;
      cap_we     <= 1'b0;
      cap_mt     <= '0;
      cap_addr   <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
      if (commit) begin
        rd_q   <= commit_rd;
        data_q <= commit_data;
      end
      if (capture) begin
        cap_rd   <= rd_i;
        cap_we   <= we_i;
        cap_mt   <= mem_type_i;
        cap_addr <= addr_lo_i;
      end
    end
  end

  assign ready_o    = (state_q == WB_IDLE);
  assign DATA_in_WB = data_q;
  assign misalign_o = misalign_q;

  always_comb begin
    Control_Signal_WB                 = '0;
    Control_Signal_WB[WE_BIT]         = we_q;
    Control_Signal_WB[RD_LSB +: 5]    = rd_q;
  end

`ifdef WB_RETIRE_CNT_EN
  // Counts in step with the we pulse it accounts for.
  logic [63:0] cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt_q <= '0;
    else if (we_d) cnt_q <= cnt_q + 64'd1;
  end
  assign retire_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed test-plan steps followed by random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_wb_commit_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, ready_o, we_i, md_i, rdata_valid_i, misalign_o;
  logic [4:0]  rd_i;
  logic [2:0]  mem_type_i;
  logic [1:0]  addr_lo_i;
  logic [31:0] alu_result_i, rdata_i, DATA_in_WB;
  logic [5:0]  Control_Signal_WB;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: committed write-port contents and the pending load, if any.
  logic        m_busy, m_we, m_mis;
  logic [4:0]  m_rd, p_rd;
  logic [31:0] m_data;
  logic        p_we;
  logic [2:0]  p_mt;
  logic [1:0]  p_a;
  longint unsigned m_cnt;

  always #5 clk = ~clk;

  wb_commit_stage dut (
    .clk               (clk),
    .reset             (reset),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .rd_i              (rd_i),
    .we_i              (we_i),
    .md_i              (md_i),
    .mem_type_i        (mem_type_i),
    .addr_lo_i         (addr_lo_i),
    .alu_result_i      (alu_result_i),
    .rdata_valid_i     (rdata_valid_i),
    .rdata_i           (rdata_i),
    .Control_Signal_WB (Control_Signal_WB),
    .DATA_in_WB        (DATA_in_WB),
    .misalign_o        (misalign_o)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o      (retire_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from the funct3 code; unknown codes act as words.
  function automatic int acc_bytes(input logic [2:0] mt);
    case (mt)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_align(input logic [2:0] mt, input logic [1:0] a,
                                             input logic [31:0] word);
    int n = acc_bytes(mt);
    longint v;
    if (n == 4) return word;
    v = longint'((word >> (8 * int'(a))) & ((32'd1 << (8 * n)) - 1));
    if (mt[2] == 1'b0 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_mis = 0; m_rd = 0; m_data = 0; m_cnt = 0;
    p_rd = 0; p_we = 0; p_mt = 0; p_a = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, 64'(ready_o), 64'(!m_busy));
    chk({tag, ".ctrl"}, 64'(Control_Signal_WB), 64'({m_rd, m_we}));
    chk({tag, ".data"}, 64'(DATA_in_WB), 64'(m_data));
    chk({tag, ".mis"}, 64'(misalign_o), 64'(m_mis));
`ifdef WB_RETIRE_CNT_EN
    chk({tag, ".cnt"}, retire_cnt_o, m_cnt);
`endif
  endtask

  // One clock with the given inputs; model advanced from the same inputs.
  task automatic cyc(input string tag, input logic v, input logic md, input logic [4:0] rd,
                     input logic we, input logic [2:0] mt, input logic [1:0] a,
                     input logic [31:0] alu, input logic rdv, input logic [31:0] rdata);
    valid_i = v; md_i = md; rd_i = rd; we_i = we; mem_type_i = mt; addr_lo_i = a;
    alu_result_i = alu; rdata_valid_i = rdv; rdata_i = rdata;
    m_we = 0; m_mis = 0;
    if (!m_busy) begin
      if (v && !md) begin
        m_we = we && (rd != 0); m_rd = rd; m_data = alu;
      end else if (v && md) begin
        if ((int'(a) % acc_bytes(mt)) != 0) m_mis = 1;
        else begin m_busy = 1; p_rd = rd; p_we = we; p_mt = mt; p_a = a; end
      end
    end else if (rdv) begin
      m_we = p_we && (p_rd != 0); m_rd = p_rd; m_data = ref_align(p_mt, p_a, rdata); m_busy = 0;
    end
    if (m_we) m_cnt++;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 5'd0, 0, 3'd0, 2'd0, $urandom, 0, $urandom);
  endtask

  initial begin
    reset = 0;
    valid_i = 0; md_i = 0; rd_i = 0; we_i = 0; mem_type_i = 0; addr_lo_i = 0;
    alu_result_i = 0; rdata_valid_i = 0; rdata_i = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); reset = 1;

    cyc("alu", 1, 0, 5'd5, 1, 3'd0, 2'd0, 32'h1234_5678, 0, 0);
    chk("alu_ctrl_const", 64'(Control_Signal_WB), 64'(6'b001011));
    chk("alu_data_const", 64'(DATA_in_WB), 64'h1234_5678);
    idle("alu_after");
    chk("alu_we_drop", 64'(Control_Signal_WB[0]), 64'd0);

    cyc("x0", 1, 0, 5'd0, 1, 3'd0, 2'd0, 32'hDEAD_BEEF, 0, 0);
    chk("x0_we", 64'(Control_Signal_WB[0]), 64'd0);

    cyc("b2b0", 1, 0, 5'd3, 1, 3'd0, 2'd0, 32'h0000_0003, 0, 0);
    cyc("b2b1", 1, 0, 5'd4, 1, 3'd0, 2'd0, 32'h0000_0004, 0, 0);

    cyc("lb_acc", 1, 1, 5'd7, 1, 3'b000, 2'd3, 0, 0, 0);
    chk("lb_busy0", 64'(ready_o), 64'd0);
    idle("lb_w1");
    idle("lb_w2");
    chk("lb_busy2", 64'(ready_o), 64'd0);
    cyc("lb_data", 0, 0, 5'd0, 0, 3'd0, 2'd0, 0, 1, 32'h80FF_FF7F);
    chk("lb_val", 64'(DATA_in_WB), 64'hFFFF_FF80);
    chk("lb_ctrl", 64'(Control_Signal_WB), 64'({5'd7, 1'b1}));

    cyc("lhu_acc", 1, 1, 5'd9, 1, 3'b101, 2'd2, 0, 0, 0);
    cyc("lhu_data", 0, 0, 5'd0, 0, 3'd0, 2'd0, 0, 1, 32'h8001_7FFF);
    chk("lhu_val", 64'(DATA_in_WB), 64'h0000_8001);
    cyc("lh_acc", 1, 1, 5'd10, 1, 3'b001, 2'd0, 0, 0, 0);
    cyc("lh_data", 0, 0, 5'd0, 0, 3'd0, 2'd0, 0, 1, 32'h8001_7FFF);
    chk("lh_val", 64'(DATA_in_WB), 64'h0000_7FFF);

    cyc("mis", 1, 1, 5'd11, 1, 3'b010, 2'd1, 0, 0, 0);
    chk("mis_pulse", 64'(misalign_o), 64'd1);
    chk("mis_ready", 64'(ready_o), 64'd1);
    idle("mis_after");
    chk("mis_drop", 64'(misalign_o), 64'd0);

    idle("stray_rdv_pre");
    cyc("stray_rdv", 0, 0, 5'd0, 0, 3'd0, 2'd0, 0, 1, 32'h5555_AAAA);

    cyc("rst_acc", 1, 1, 5'd12, 1, 3'b010, 2'd0, 0, 0, 0);
    @(negedge clk); reset = 0;
    model_reset();
    #1 check_all("rst_mid");
    @(negedge clk); reset = 1;
    cyc("rst_rdv", 0, 0, 5'd0, 0, 3'd0, 2'd0, 0, 1, 32'hFFFF_FFFF);
    chk("rst_rdv_ctrl", 64'(Control_Signal_WB), 64'd0);
    chk("rst_rdv_data", 64'(DATA_in_WB), 64'd0);

    for (int i = 0; i < 600; i++) begin
      logic v, md, we, rdv;
      logic [4:0] rd;
      logic [2:0] mt;
      v   = ($urandom_range(0, 3) != 0);
      md  = $urandom_range(0, 1);
      we  = ($urandom_range(0, 4) != 0);
      rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      mt  = 3'($urandom);
      rdv = ($urandom_range(0, 2) == 0);
      cyc("rnd", v, md, rd, we, mt, 2'($urandom), $urandom, rdv, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
